// File: rtl/triangle_assembler.sv
// Triangle assembler: collects three consecutive vertices (first one flagged by
// new_triangle) into a triangle and queues it in a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   vertex[47:0]       : {x, y, z} signed 16-bit each, passed through untouched
//   color[15:0]        : face color, sampled with the first vertex
//   new_triangle       : marks the first vertex; vertices 2 and 3 follow back-to-back
//   tri_v0/v1/v2       : head-of-FIFO vertices in arrival order (0 when empty)
//   tri_color          : head-of-FIFO color (0 when empty)
//   tri_valid          : head entry present
//   tri_ready          : consumer accepts head; pop on tri_valid && tri_ready
//   fifo_count         : occupied FIFO entries
//   busy               : collection in progress or FIFO not empty
//   drop_count         : triangles lost to a full FIFO (saturating)
//   abort_count        : partial triangles discarded (saturating)
module triangle_assembler #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [47:0]                   vertex,
  input  logic [15:0]                   color,
  input  logic                          new_triangle,
  output logic [47:0]                   tri_v0,
  output logic [47:0]                   tri_v1,
  output logic [47:0]                   tri_v2,
  output logic [15:0]                   tri_color,
  output logic                          tri_valid,
  input  logic                          tri_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic [7:0]                    drop_count,
  output logic [7:0]                    abort_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, GOT1, GOT2} state_e;

  state_e state_q, state_d;

  logic          latch_v0, latch_v1, push_req, abort;
  logic [47:0]   v0_q, v1_q;
  logic [15:0]   color_q;

  logic [159:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    drop_q, abort_q;
  logic          full, do_push, do_pop, drop;
  logic [159:0]  head;

  // ---------------- collect FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (new_triangle) state_d = GOT1;
      GOT1:    state_d = new_triangle ? GOT1 : GOT2;
      GOT2:    state_d = new_triangle ? GOT1 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    latch_v0 = new_triangle;
    latch_v1 = (state_q == GOT1) && !new_triangle;
    push_req = (state_q == GOT2) && !new_triangle;
    abort    = (state_q != IDLE) && new_triangle;
  end

  // ---------------- staging registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q    <= '0;
      v1_q    <= '0;
      color_q <= '0;
    end else begin
      if (latch_v0) begin
        v0_q    <= vertex;
        color_q <= color;
      end
      if (latch_v1) v1_q <= vertex;
    end
  end

  // ---------------- FIFO ----------------
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign do_pop  = tri_valid && tri_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_req && (!full || do_pop);
  assign drop    = push_req && full && !do_pop;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {v0_q, v1_q, vertex, color_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      abort_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (drop && drop_q != '1)   drop_q  <= drop_q + 1'b1;
      if (abort && abort_q != '1) abort_q <= abort_q + 1'b1;
    end
  end

  // ---------------- outputs ----------------
  assign head        = mem_q[rd_ptr_q];
  assign tri_valid   = (count_q != '0);
  assign tri_v0      = tri_valid ? head[159:112] : '0;
  assign tri_v1      = tri_valid ? head[111:64]  : '0;
  assign tri_v2      = tri_valid ? head[63:16]   : '0;
  assign tri_color   = tri_valid ? head[15:0]    : '0;
  assign fifo_count  = count_q;
  assign busy        = (state_q != IDLE) || (count_q != '0);
  assign drop_count  = drop_q;
  assign abort_count = abort_q;

endmodule

// File: tb/tb_triangle_assembler.sv
// Directed bench for triangle_assembler: single triangle, streaming, overflow,
// full-with-pop, abort and mid-operation reset. A negedge monitor compares every
// popped triangle against a queue of expected triangles.
module tb_triangle_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] vertex;
  logic [15:0] color;
  logic        new_triangle;
  logic [47:0] tri_v0, tri_v1, tri_v2;
  logic [15:0] tri_color;
  logic        tri_valid;
  logic        tri_ready;
  logic [2:0]  fifo_count;
  logic        busy;
  logic [7:0]  drop_count, abort_count;

  triangle_assembler #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .vertex      (vertex),
    .color       (color),
    .new_triangle(new_triangle),
    .tri_v0      (tri_v0),
    .tri_v1      (tri_v1),
    .tri_v2      (tri_v2),
    .tri_color   (tri_color),
    .tri_valid   (tri_valid),
    .tri_ready   (tri_ready),
    .fifo_count  (fifo_count),
    .busy        (busy),
    .drop_count  (drop_count),
    .abort_count (abort_count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned pop_n    = 0;
  logic [159:0] exp_q[$];

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one triangle on three consecutive cycles, leaving new_triangle low.
  task automatic send_tri(input logic [47:0] a, input logic [47:0] b,
                          input logic [47:0] c, input logic [15:0] col);
    vertex = a; color = col; new_triangle = 1'b1; step();
    vertex = b; color = '0;  new_triangle = 1'b0; step();
    vertex = c;                                   step();
  endtask

  function automatic logic [47:0] mkv(input int unsigned id, input int unsigned k);
    return {16'(id), 16'(16'h0100 + k), 16'(16'h00F0 + id * 3 + k)};
  endfunction

  // Monitor: each pop is compared against the oldest expected triangle.
  always @(negedge clk) begin
    if (rst === 1'b0 && tri_valid === 1'b1 && tri_ready === 1'b1) begin
      pop_n++;
      if (exp_q.size() == 0)
        check("pop_expected_q_size", 160'(exp_q.size()), 160'(1));
      else
        check("pop_data", {tri_v0, tri_v1, tri_v2, tri_color}, exp_q.pop_front());
    end
  end

  logic [15:0] cols [10] = '{16'h0400, 16'h0400, 16'h0200, 16'h0200, 16'h0200,
                             16'h0200, 16'h1404, 16'h1404, 16'h2204, 16'h2204};
  int unsigned pop_base;

  initial begin
    rst = 1'b1; vertex = '0; color = '0; new_triangle = 1'b0; tri_ready = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_valid", 160'(tri_valid), 160'(0));
    check("rst_count", 160'(fifo_count), 160'(0));
    check("rst_busy",  160'(busy), 160'(0));
    check("rst_drop",  160'(drop_count), 160'(0));
    check("rst_abort", 160'(abort_count), 160'(0));
    check("rst_v0",    160'(tri_v0), 160'(0));

    // Single triangle, 1-cycle latency, held while not ready
    send_tri(48'hFFF0_0000_00F0, 48'h0010_0000_00F0, 48'hFFF0_FFE0_00F0, 16'h0400);
    check("single_valid", 160'(tri_valid), 160'(1));
    check("single_v0", 160'(tri_v0), 160'(48'hFFF0_0000_00F0));
    check("single_v1", 160'(tri_v1), 160'(48'h0010_0000_00F0));
    check("single_v2", 160'(tri_v2), 160'(48'hFFF0_FFE0_00F0));
    check("single_color", 160'(tri_color), 160'(16'h0400));
    check("single_count", 160'(fifo_count), 160'(1));
    step();
    check("single_hold_v0", 160'(tri_v0), 160'(48'hFFF0_0000_00F0));
    exp_q.push_back({48'hFFF0_0000_00F0, 48'h0010_0000_00F0, 48'hFFF0_FFE0_00F0, 16'h0400});
    tri_ready = 1'b1;
    step();
    check("single_popped_count", 160'(fifo_count), 160'(0));
    check("single_pop_n", 160'(pop_n), 160'(1));

    // Stream of 10 back-to-back triangles with tri_ready=1
    pop_base = pop_n;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({mkv(10 + i, 0), mkv(10 + i, 1), mkv(10 + i, 2), cols[i]});
      send_tri(mkv(10 + i, 0), mkv(10 + i, 1), mkv(10 + i, 2), cols[i]);
    end
    step(); step();
    check("stream_pops", 160'(pop_n - pop_base), 160'(10));
    check("stream_q_empty", 160'(exp_q.size()), 160'(0));
    check("stream_drop", 160'(drop_count), 160'(0));
    check("stream_abort", 160'(abort_count), 160'(0));
    check("stream_count", 160'(fifo_count), 160'(0));

    // Overflow: 5 triangles into a depth-4 FIFO with tri_ready=0
    tri_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back({mkv(30 + i, 0), mkv(30 + i, 1), mkv(30 + i, 2), 16'(16'h3000 + i)});
      send_tri(mkv(30 + i, 0), mkv(30 + i, 1), mkv(30 + i, 2), 16'(16'h3000 + i));
    end
    check("ovf_count", 160'(fifo_count), 160'(4));
    check("ovf_drop", 160'(drop_count), 160'(1));
    check("ovf_head_v0", 160'(tri_v0), 160'(mkv(30, 0)));
    pop_base = pop_n;
    tri_ready = 1'b1;
    repeat (6) step();
    tri_ready = 1'b0;
    check("ovf_pops", 160'(pop_n - pop_base), 160'(4));
    check("ovf_q_empty", 160'(exp_q.size()), 160'(0));

    // Full FIFO, push coincides with a pop
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({mkv(40 + i, 0), mkv(40 + i, 1), mkv(40 + i, 2), 16'(16'h4000 + i)});
      send_tri(mkv(40 + i, 0), mkv(40 + i, 1), mkv(40 + i, 2), 16'(16'h4000 + i));
    end
    check("fullpop_pre_count", 160'(fifo_count), 160'(4));
    exp_q.push_back({mkv(44, 0), mkv(44, 1), mkv(44, 2), 16'h4004});
    pop_base = pop_n;
    vertex = mkv(44, 0); color = 16'h4004; new_triangle = 1'b1; step();
    vertex = mkv(44, 1); color = '0; new_triangle = 1'b0; step();
    vertex = mkv(44, 2); tri_ready = 1'b1; step();
    tri_ready = 1'b0;
    check("fullpop_count", 160'(fifo_count), 160'(4));
    check("fullpop_drop", 160'(drop_count), 160'(1));
    check("fullpop_head", 160'(tri_v0), 160'(mkv(41, 0)));
    tri_ready = 1'b1;
    repeat (6) step();
    tri_ready = 1'b0;
    check("fullpop_pops", 160'(pop_n - pop_base), 160'(5));
    check("fullpop_q_empty", 160'(exp_q.size()), 160'(0));

    // Abort in GOT2: new v0 comes from the abort cycle
    vertex = mkv(50, 0); color = 16'h5000; new_triangle = 1'b1; step();
    vertex = mkv(50, 1); color = '0; new_triangle = 1'b0; step();
    vertex = mkv(51, 0); color = 16'h5100; new_triangle = 1'b1; step();
    check("abort_count", 160'(abort_count), 160'(1));
    check("abort_no_push", 160'(fifo_count), 160'(0));
    vertex = mkv(51, 1); color = '0; new_triangle = 1'b0; step();
    vertex = mkv(51, 2); step();
    check("abort_count_after", 160'(fifo_count), 160'(1));
    check("abort_tri", {tri_v0, tri_v1, tri_v2, tri_color},
          {mkv(51, 0), mkv(51, 1), mkv(51, 2), 16'h5100});

    // Reset mid-operation: FIFO holds 2, FSM in GOT1
    send_tri(mkv(60, 0), mkv(60, 1), mkv(60, 2), 16'h6000);
    vertex = mkv(61, 0); color = 16'h6100; new_triangle = 1'b1; step();
    check("prerst_count", 160'(fifo_count), 160'(2));
    check("prerst_busy", 160'(busy), 160'(1));
    rst = 1'b1; vertex = mkv(62, 0); color = 16'h6200; new_triangle = 1'b1; step();
    rst = 1'b0; new_triangle = 1'b0; exp_q.delete();
    check("midrst_valid", 160'(tri_valid), 160'(0));
    check("midrst_count", 160'(fifo_count), 160'(0));
    check("midrst_busy", 160'(busy), 160'(0));
    check("midrst_drop", 160'(drop_count), 160'(0));
    check("midrst_abort", 160'(abort_count), 160'(0));
    check("midrst_data", {tri_v0, tri_v1, tri_v2, tri_color}, 160'(0));

    // First triangle right after reset deasserts
    send_tri(mkv(70, 0), mkv(70, 1), mkv(70, 2), 16'h7000);
    check("postrst_valid", 160'(tri_valid), 160'(1));
    check("postrst_tri", {tri_v0, tri_v1, tri_v2, tri_color},
          {mkv(70, 0), mkv(70, 1), mkv(70, 2), 16'h7000});
    check("postrst_abort", 160'(abort_count), 160'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
